// File: rtl/mdio_peripheral.sv
// mdio_peripheral: PHY-side MDIO management target.
// Decodes serial frames from the controller and serves a local register port.
module mdio_peripheral #(
    parameter bit BROADCAST_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  PHY_ADDR,
    input  logic        MDC,
    input  logic        MDIO_OUT,
    input  logic        MDIO_OE,
    output logic        MDIO_IN,
    output logic        MDIO_IN_OE,
    output logic [4:0]  REG_ADDR,
    output logic [15:0] REG_WDATA,
    output logic        REG_WE,
    output logic        REG_RE,
    input  logic [15:0] REG_RDATA,
    output logic        BUSY,
    output logic        FRAME_ERR
);

    typedef enum logic [3:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD,
        S_WR_TA, S_WR_DATA, S_RD_TA, S_RD_DATA, S_SKIP
    } state_t;

    state_t      state_q, state_d;
    logic        mdc_q;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  phy_q, phy_d;
    logic [4:0]  regad_q, regad_d;
    logic [15:0] wsh_q, wsh_d;
    logic [15:0] rsh_q, rsh_d;
    logic        re_dly_q, re_dly_d;
    logic        mdio_in_q, mdio_in_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic rise;
    logic wr_ph;
    logic rd_ph;
    logic abort;
    logic hit;

    assign rise  = MDC & ~mdc_q;
    assign wr_ph = (state_q == S_WR_TA) || (state_q == S_WR_DATA);
    assign rd_ph = (state_q == S_RD_TA) || (state_q == S_RD_DATA);

    // Controller must drive through the address phase and all of a write;
    // it must stay off the line while we return read data.
    assign abort = (state_q != S_IDLE) &&
                   ((!MDIO_OE && (cnt_q <= 5'd13 || wr_ph)) ||
                    (MDIO_OE && rd_ph && cnt_q >= 5'd15));

    assign hit = (phy_q == PHY_ADDR) ||
                 (BROADCAST_EN && phy_q == 5'd0 && op_q == 2'b01);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        phy_d     = phy_q;
        regad_d   = regad_q;
        wsh_d     = wsh_q;
        rsh_d     = rsh_q;
        re_dly_d  = re_q;
        mdio_in_d = mdio_in_q;
        mdio_oe_d = mdio_oe_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        err_d     = 1'b0;
        if (re_dly_q) begin
            rsh_d = REG_RDATA;
        end
        if (rise) begin
            cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
            if (abort) begin
                state_d   = S_IDLE;
                err_d     = 1'b1;
                mdio_oe_d = 1'b0;
                mdio_in_d = 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (MDIO_OE && !MDIO_OUT) begin
                            state_d = S_ST;
                        end
                    end
                    S_ST: begin
                        if (MDIO_OUT) begin
                            state_d = S_OP;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_OP: begin
                        op_d = {op_q[0], MDIO_OUT};
                        if (cnt_q == 5'd3) begin
                            if (op_d == 2'b01 || op_d == 2'b10) begin
                                state_d = S_PHYAD;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_SKIP;
                            end
                        end
                    end
                    S_PHYAD: begin
                        phy_d = {phy_q[3:0], MDIO_OUT};
                        if (cnt_q == 5'd8) begin
                            state_d = S_REGAD;
                        end
                    end
                    S_REGAD: begin
                        regad_d = {regad_q[3:0], MDIO_OUT};
                        if (cnt_q == 5'd13) begin
                            if (!hit) begin
                                state_d = S_SKIP;
                            end else if (op_q == 2'b10) begin
                                addr_d  = regad_d;
                                re_d    = 1'b1;
                                state_d = S_RD_TA;
                            end else begin
                                addr_d  = regad_d;
                                state_d = S_WR_TA;
                            end
                        end
                    end
                    S_WR_TA: begin
                        if (cnt_q == 5'd15) begin
                            state_d = S_WR_DATA;
                        end
                    end
                    S_WR_DATA: begin
                        wsh_d = {wsh_q[14:0], MDIO_OUT};
                        if (cnt_q == 5'd31) begin
                            wdata_d = wsh_d;
                            we_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_RD_TA: begin
                        if (cnt_q == 5'd14) begin
                            mdio_oe_d = 1'b1;
                            mdio_in_d = 1'b0;
                        end else begin
                            mdio_in_d = rsh_q[15];
                            rsh_d     = {rsh_q[14:0], 1'b0};
                            state_d   = S_RD_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        if (cnt_q == 5'd31) begin
                            mdio_oe_d = 1'b0;
                            mdio_in_d = 1'b0;
                            state_d   = S_IDLE;
                        end else begin
                            mdio_in_d = rsh_q[15];
                            rsh_d     = {rsh_q[14:0], 1'b0};
                        end
                    end
                    S_SKIP: begin
                        if (cnt_q == 5'd31) begin
                            state_d = S_IDLE;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
            if (state_d == S_IDLE) begin
                cnt_d = 5'd0;
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            mdc_q     <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
            phy_q     <= '0;
            regad_q   <= '0;
            wsh_q     <= '0;
            rsh_q     <= '0;
            re_dly_q  <= 1'b0;
            mdio_in_q <= 1'b0;
            mdio_oe_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mdc_q     <= MDC;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            phy_q     <= phy_d;
            regad_q   <= regad_d;
            wsh_q     <= wsh_d;
            rsh_q     <= rsh_d;
            re_dly_q  <= re_dly_d;
            mdio_in_q <= mdio_in_d;
            mdio_oe_q <= mdio_oe_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign MDIO_IN    = mdio_in_q;
    assign MDIO_IN_OE = mdio_oe_q;
    assign REG_ADDR   = addr_q;
    assign REG_WDATA  = wdata_q;
    assign REG_WE     = we_q;
    assign REG_RE     = re_q;
    assign BUSY       = busy_q;
    assign FRAME_ERR  = err_q;

endmodule

// File: tb/tb_mdio_peripheral.sv
// tb_mdio_peripheral: random MDIO frames from a behavioural controller,
// expected register-port events queued and matched by a separate monitor.
module tb_mdio_peripheral;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [4:0]  PHY_ADDR = 5'd1;
    logic        MDC = 1'b0;
    logic        MDIO_OUT = 1'b1;
    logic        MDIO_OE = 1'b0;
    logic [15:0] REG_RDATA = '0;
    logic        MDIO_IN, MDIO_IN_OE, REG_WE, REG_RE, BUSY, FRAME_ERR;
    logic [4:0]  REG_ADDR;
    logic [15:0] REG_WDATA;

    typedef enum logic [1:0] {EV_WE, EV_RE, EV_ERR, EV_RD} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [4:0]  addr;
        logic [16:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [16:0] act_rd[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] rd_val = '0;
    logic        re_seen = 1'b0;

    mdio_peripheral #(.BROADCAST_EN(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .PHY_ADDR(PHY_ADDR),
        .MDC(MDC), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
        .MDIO_IN(MDIO_IN), .MDIO_IN_OE(MDIO_IN_OE),
        .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA),
        .REG_WE(REG_WE), .REG_RE(REG_RE), .REG_RDATA(REG_RDATA),
        .BUSY(BUSY), .FRAME_ERR(FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    // Register file: read data valid only in the cycle after REG_RE.
    always @(negedge CLK) begin
        REG_RDATA = re_seen ? rd_val : 16'($urandom);
        re_seen   = REG_RE;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void push(input ev_kind_t k, input logic [4:0] a,
                                 input logic [16:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic expect_ev(input ev_kind_t k, input logic [4:0] a,
                             input logic [16:0] d);
        ev_t  e;
        logic use_a, use_d;
        use_a = (k == EV_WE) || (k == EV_RE);
        use_d = (k == EV_WE) || (k == EV_RD);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s actual=%0h/%0h required=none",
                     k.name(), a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (use_a && e.addr !== a) ||
                (use_d && e.data !== d)) begin
                errors++;
                $display("FAIL event actual=%s/%0h/%0h required=%s/%0h/%0h",
                         k.name(), a, d, e.kind.name(), e.addr, e.data);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            if (REG_WE) expect_ev(EV_WE, REG_ADDR, {1'b0, REG_WDATA});
            if (REG_RE) expect_ev(EV_RE, REG_ADDR, '0);
            if (FRAME_ERR) expect_ev(EV_ERR, '0, '0);
            if (act_rd.size() != 0) expect_ev(EV_RD, '0, act_rd.pop_front());
        end
    end

    task automatic send_bit(input logic b, input logic oe, output logic din,
                            output logic doe, output logic bsy);
        MDC = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge CLK);
        din = MDIO_IN;
        doe = MDIO_IN_OE;
        bsy = BUSY;
        MDC = 1'b1;
        MDIO_OUT = b;
        MDIO_OE = oe;
        repeat ($urandom_range(1, 3)) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [31:0] fr, input logic [31:0] oe,
                              input int last, output logic [16:0] rbits,
                              output logic [16:0] roe, output logic bsy_ok);
        logic din, doe, bsy;
        rbits  = '0;
        roe    = '0;
        bsy_ok = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1, din, doe, bsy);
        for (int i = 0; i <= last; i++) begin
            send_bit(fr[31-i], oe[31-i], din, doe, bsy);
            if (i >= 15) begin
                rbits[31-i] = din;
                roe[31-i]   = doe;
            end
            if (i >= 1 && !bsy) bsy_ok = 1'b0;
        end
        MDC = 1'b0;
        MDIO_OE = 1'b0;
        MDIO_OUT = 1'b1;
        repeat (6) @(negedge CLK);
    endtask

    // typ: 0 write, 1 read, 2 bad opcode, 3 bad start.
    // fault: edge where the controller misbehaves on MDIO_OE, -1 none.
    task automatic run_frame(input int typ, input logic [4:0] phy,
                             input logic [4:0] ra, input logic [15:0] d,
                             input logic [1:0] bad_op, input int fault);
        logic [31:0] fr, oe;
        logic [16:0] rbits, roe;
        logic        bsy_ok;
        logic [1:0]  op;
        int          last;
        bit          ok, want_rd;
        op = (typ == 0) ? 2'b01 : (typ == 1) ? 2'b10 :
             (typ == 2) ? bad_op : 2'b01;
        fr = {1'b0, (typ == 3) ? 1'b0 : 1'b1, op, phy, ra,
              (typ == 1) ? 2'b11 : 2'b10, (typ == 1) ? 16'hFFFF : d};
        oe = (typ == 1) ? 32'hFFFC_0000 : 32'hFFFF_FFFF;
        if (fault >= 0) oe[31-fault] = ~oe[31-fault];
        ok = (phy == PHY_ADDR) || (typ == 0 && phy == 5'd0);
        last = 31;
        want_rd = 1'b0;
        if (typ == 3) begin
            push(EV_ERR, '0, '0);
            last = 1;
        end else if (fault >= 1 && fault <= 13) begin
            push(EV_ERR, '0, '0);
            last = fault;
        end else if (typ == 2) begin
            push(EV_ERR, '0, '0);
        end else if (ok && typ == 0) begin
            if (fault >= 14) begin
                push(EV_ERR, '0, '0);
                last = fault;
            end else begin
                push(EV_WE, ra, {1'b0, d});
            end
        end else if (ok) begin
            push(EV_RE, ra, '0);
            if (fault >= 15) begin
                push(EV_ERR, '0, '0);
                last = fault;
            end else begin
                push(EV_RD, '0, {1'b0, d});
                want_rd = 1'b1;
            end
        end
        rd_val = d;
        send_frame(fr, oe, last, rbits, roe, bsy_ok);
        if (want_rd) begin
            act_rd.push_back(rbits);
            check("rd_drive_oe", 32'(roe), 32'h1FFFF);
        end
        repeat (3) @(negedge CLK);
        check("busy_in_frame", 32'(bsy_ok), 32'd1);
        check("drain", exp_q.size(), 32'd0);
        check("idle_busy", 32'(BUSY), 32'd0);
        check("idle_line", {30'd0, MDIO_IN_OE, MDIO_IN}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [16:0] rb, ro;
        logic        bo;
        int          typ, fault, r;
        logic [4:0]  phy;
        bit          hit;
        repeat (3) @(negedge CLK);
        check("reset_state", {5'd0, MDIO_IN, MDIO_IN_OE, REG_ADDR, REG_WDATA,
              REG_WE, REG_RE, BUSY, FRAME_ERR}, 32'd0);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);

        PHY_ADDR = 5'd1;
        run_frame(0, 5'd1, 5'd2, 16'hABCD, 2'b00, -1);
        PHY_ADDR = 5'd3;
        run_frame(1, 5'd3, 5'd4, 16'hA5C3, 2'b00, -1);
        check("hold_regs", {11'd0, REG_ADDR, REG_WDATA}, {11'd0, 5'd4, 16'hABCD});
        PHY_ADDR = 5'd1;
        run_frame(0, 5'd5, 5'd9, 16'h1111, 2'b00, -1);
        run_frame(2, 5'd1, 5'd3, 16'h0000, 2'b11, -1);
        run_frame(0, 5'd1, 5'd3, 16'hBEEF, 2'b00, -1);

        send_frame({2'b01, 2'b01, 5'd1, 5'd7, 2'b10, 16'h1234}, '1, 20,
                   rb, ro, bo);
        RESET = 1'b0;
        #1;
        check("reset_mid_frame", {5'd0, MDIO_IN, MDIO_IN_OE, REG_ADDR,
              REG_WDATA, REG_WE, REG_RE, BUSY, FRAME_ERR}, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check("reset_no_event", exp_q.size(), 32'd0);
        run_frame(0, 5'd1, 5'd11, 16'h600D, 2'b00, -1);

        run_frame(0, 5'd1, 5'd6, 16'h7777, 2'b00, 20);
        run_frame(0, 5'd0, 5'd8, 16'h5A5A, 2'b00, -1);
        run_frame(1, 5'd0, 5'd2, 16'h1234, 2'b00, -1);
        run_frame(1, 5'd1, 5'd4, 16'hF00F, 2'b00, 22);
        run_frame(3, 5'd1, 5'd1, 16'h0000, 2'b00, -1);
        run_frame(0, 5'd1, 5'd1, 16'h0001, 2'b00, 5);
        run_frame(1, 5'd1, 5'd31, 16'h8001, 2'b00, -1);

        for (int n = 0; n < 40; n++) begin
            PHY_ADDR = 5'($urandom_range(1, 31));
            r = $urandom_range(0, 9);
            typ = (r < 4) ? 0 : (r < 8) ? 1 : (r < 9) ? 2 : 3;
            r = $urandom_range(0, 9);
            phy = (r < 5) ? PHY_ADDR : (r < 7) ? 5'd0 : 5'($urandom);
            fault = -1;
            r = $urandom_range(0, 9);
            if (typ < 2 && r < 2) begin
                fault = $urandom_range(1, 13);
            end else if (typ < 2 && r < 4) begin
                fault = (typ == 0) ? $urandom_range(14, 31) :
                                     $urandom_range(15, 31);
            end
            hit = (phy == PHY_ADDR) || (typ == 0 && phy == 5'd0);
            if (fault > 13 && !hit) fault = -1;
            run_frame(typ, phy, 5'($urandom), 16'($urandom),
                      $urandom_range(0, 1) ? 2'b00 : 2'b11, fault);
        end

        repeat (5) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
